// File: rtl/fifo_frame_read_pkg.sv
// Shared definitions for the command-frame FIFO reader: FSM state
// encoding, error-bit positions and the frame length helper.
package fifo_rd_pkg;

  localparam int NUM_W = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_CHEK = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int ERR_HEAD = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_CHK  = 2;
  localparam int ERR_TOUT = 3;

  // Expected frame length: header byte + payload + optional checksum byte.
  function automatic logic [NUM_W-1:0] exp_len(input int nreg, input int chk_en);
    return NUM_W'(1 + nreg + ((chk_en != 0) ? 1 : 0));
  endfunction

endpackage

// File: rtl/fifo_frame_read_chk.sv
// Running XOR over the payload bytes of a frame, compared against the
// checksum byte when its index comes past. Cleared between frames.
module frame_chk
  import fifo_rd_pkg::*;
#(
  parameter int NREG = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_din,
  input  logic [NUM_W-1:0] i_idx,
  output logic             o_bad
);

  localparam logic [NUM_W-1:0] PAY_LAST = NUM_W'(NREG);
  localparam logic [NUM_W-1:0] CHK_IDX  = NUM_W'(NREG + 1);

  logic [7:0] r_xor;
  logic       r_bad;

  // Accumulate payload bytes 1..NREG; latch the compare on the checksum byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_xor <= 8'h00;
      r_bad <= 1'b0;
    end else if (i_clr) begin
      r_xor <= 8'h00;
      r_bad <= 1'b0;
    end else if (i_en) begin
      if ((i_idx >= NUM_W'(1)) && (i_idx <= PAY_LAST))
        r_xor <= r_xor ^ i_din;
      if (i_idx == CHK_IDX)
        r_bad <= (i_din != r_xor);
    end
  end

  assign o_bad = r_bad;

endmodule

// File: rtl/fifo_frame_read.sv
// Drains one command frame from the command FIFO, checks header, length
// and checksum, and commits the payload to the register bank when clean.
//
// state | meaning
// IDLE  | waiting for fs from the sequencer
// WAIT  | waiting until the FIFO holds the whole frame (with timeout)
// READ  | issuing fifo_num reads and capturing bytes one cycle later
// CHEK  | all bytes captured; fold in checksum result, commit if clean
// DONE  | fd high until the sequencer drops fs
module fifo_frame_read
  import fifo_rd_pkg::*;
#(
  parameter int         NREG    = 12,
  parameter logic [7:0] HEAD    = 8'h55,
  parameter int         CHK_EN  = 1,
  parameter int         CNT_W   = 10,
  parameter int         TIMEOUT = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fs,
  output logic              o_fd,
  input  logic [NUM_W-1:0]  i_fifo_num,
  input  logic [CNT_W-1:0]  i_fifo_cnt,
  input  logic [7:0]        i_fifo_rxd,
  output logic              o_fifo_rxen,
  output logic [NREG*8-1:0] o_res,
  output logic              o_res_vld,
  output logic [3:0]        o_err,
  output logic [2:0]        o_so
);

  localparam int               SW    = NREG * 8;
  localparam logic [NUM_W-1:0] EXP   = exp_len(NREG, CHK_EN);
  localparam int               TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int               CMP_W = (CNT_W > NUM_W) ? CNT_W : NUM_W;

  state_t           r_state;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_rd_cnt;
  logic [NUM_W-1:0] r_cap_idx;
  logic             r_rxen_d1;
  logic [TMO_W-1:0] r_tmo;
  logic [SW-1:0]    r_stage;
  logic             r_fd;
  logic             r_rxen;
  logic [SW-1:0]    r_res;
  logic             r_res_vld;
  logic [3:0]       r_err;

  logic             w_cnt_ok;
  logic             w_cap;
  logic             w_last;
  logic             w_chk_clr;
  logic             w_chk_bad;
  logic [3:0]       w_err_fin;

  assign w_cnt_ok  = (CMP_W'(i_fifo_cnt) >= CMP_W'(i_fifo_num));
  // FIFO data is valid the cycle after the read strobe it answers.
  assign w_cap     = r_rxen_d1;
  assign w_last    = w_cap && (r_cap_idx == (r_num - NUM_W'(1)));
  assign w_chk_clr = (r_state == S_WAIT);

  frame_chk #(
    .NREG (NREG)
  ) u_chk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_chk_clr),
    .i_en  (w_cap),
    .i_din (i_fifo_rxd),
    .i_idx (r_cap_idx),
    .o_bad (w_chk_bad)
  );

  // Checksum only counts when enabled and the length was right; otherwise
  // the checksum byte position is meaningless.
  always_comb begin
    w_err_fin = r_err;
    if ((CHK_EN != 0) && !r_err[ERR_LEN] && w_chk_bad)
      w_err_fin[ERR_CHK] = 1'b1;
  end

  // Frame sequencing FSM with counters, staging shift and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_rd_cnt  <= '0;
      r_cap_idx <= '0;
      r_rxen_d1 <= 1'b0;
      r_tmo     <= '0;
      r_stage   <= '0;
      r_fd      <= 1'b0;
      r_rxen    <= 1'b0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_err     <= 4'h0;
    end else begin
      r_res_vld <= 1'b0;
      r_rxen_d1 <= r_rxen;
      unique case (r_state)
        S_IDLE: begin
          r_fd <= 1'b0;
          if (i_fs) begin
            r_err     <= 4'h0;
            r_tmo     <= TMO_W'(TIMEOUT - 1);
            r_rd_cnt  <= '0;
            r_cap_idx <= '0;
            r_stage   <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_fifo_num == '0) begin
            r_err[ERR_LEN] <= 1'b1;
            r_fd           <= 1'b1;
            r_state        <= S_DONE;
          end else if (w_cnt_ok) begin
            // Length is frozen here; a wrong length still drains the whole
            // frame so the FIFO stays aligned on frame boundaries.
            r_num    <= i_fifo_num;
            r_err[ERR_LEN] <= (i_fifo_num != EXP);
            r_rxen   <= 1'b1;
            r_rd_cnt <= NUM_W'(1);
            r_state  <= S_READ;
          end else if (r_tmo == '0) begin
            r_err[ERR_TOUT] <= 1'b1;
            r_fd            <= 1'b1;
            r_state         <= S_DONE;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
        end
        S_READ: begin
          if (r_rxen) begin
            if (r_rd_cnt == r_num)
              r_rxen <= 1'b0;
            else
              r_rd_cnt <= r_rd_cnt + NUM_W'(1);
          end
          if (w_cap) begin
            r_cap_idx <= r_cap_idx + NUM_W'(1);
            if ((r_cap_idx == '0) && (i_fifo_rxd != HEAD))
              r_err[ERR_HEAD] <= 1'b1;
            if ((r_cap_idx >= NUM_W'(1)) && (r_cap_idx <= NUM_W'(NREG)))
              r_stage <= (r_stage << 8) | SW'(i_fifo_rxd);
          end
          if (w_last)
            r_state <= S_CHEK;
        end
        S_CHEK: begin
          r_err <= w_err_fin;
          if (w_err_fin == 4'h0) begin
            r_res     <= r_stage;
            r_res_vld <= 1'b1;
          end
          r_fd    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!i_fs) begin
            r_fd    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_fd    <= 1'b0;
          r_rxen  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fd        = r_fd;
  assign o_fifo_rxen = r_rxen;
  assign o_res       = r_res;
  assign o_res_vld   = r_res_vld;
  assign o_err       = r_err;
  assign o_so        = r_state;

endmodule

// File: tb/tb_fifo_frame_read.sv
// Directed bench for fifo_frame_read with a queue-based FIFO model.
module tb_fifo_frame_read;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [11:0] fifo_num;
  logic [9:0]  fifo_cnt;
  logic [7:0]  fifo_rxd;
  logic        fifo_rxen;
  logic [95:0] res;
  logic        res_vld;
  logic [3:0]  err;
  logic [2:0]  so;

  int vectors;
  int miscompares;
  int rd_count;
  int vld_count;
  logic [7:0] fifo_q[$];

  fifo_frame_read #(
    .NREG(12), .HEAD(8'h55), .CHK_EN(1), .CNT_W(10), .TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_fs(fs), .o_fd(fd),
    .i_fifo_num(fifo_num), .i_fifo_cnt(fifo_cnt), .i_fifo_rxd(fifo_rxd),
    .o_fifo_rxen(fifo_rxen), .o_res(res), .o_res_vld(res_vld),
    .o_err(err), .o_so(so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode FIFO: dout updates after the edge that samples rd_en.
  always @(posedge clk) begin
    if (!rst && fifo_rxen) begin
      rd_count <= rd_count + 1;
      if (fifo_q.size() > 0) fifo_rxd <= fifo_q.pop_front();
      else fifo_rxd <= 8'h00;
    end
    if (!rst && res_vld) vld_count <= vld_count + 1;
  end

  task automatic push_frame(input logic [7:0] head, input logic [7:0] base,
                            input bit bad_chk, input int extra);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    fifo_q.push_back(head);
    for (int i = 1; i <= 12; i++) begin
      b = base + 8'(i);
      x = x ^ b;
      fifo_q.push_back(b);
    end
    fifo_q.push_back(bad_chk ? 8'h00 : x);
    for (int i = 0; i < extra; i++) fifo_q.push_back(8'hE0 + 8'(i));
  endtask

  // Starts a frame, measures fs->fd latency in edges, then counts reads/pulses.
  task automatic run_frame(input logic [11:0] num, input int cnt_override,
                           output int lat, output int reads, output int vlds);
    int rb;
    int vb;
    rb = rd_count;
    vb = vld_count;
    fifo_num = num;
    fifo_cnt = (cnt_override >= 0) ? 10'(cnt_override) : 10'(fifo_q.size());
    lat = -1;
    @(negedge clk) fs = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (fd) begin
        lat = n;
        break;
      end
    end
    vectors++;
    if (lat < 0) begin
      miscompares++;
      $display("FAIL fd_wait: fd never rose within 2000 cycles, required a rise");
    end
    @(posedge clk); @(posedge clk); #1;
    reads = rd_count - rb;
    vlds  = vld_count - vb;
  endtask

  task automatic end_frame(input string name);
    @(negedge clk) fs = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (so !== 3'd0 || fd !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: so=%0d fd=%0b, required so=0 fd=0", name, so, fd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fs = 1'b0; fifo_num = '0; fifo_cnt = '0; fifo_rxd = '0;
    rd_count = 0; vld_count = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (fd !== 1'b0 || fifo_rxen !== 1'b0 || res_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: fd=%0b rxen=%0b vld=%0b, required 0 0 0", fd, fifo_rxen, res_vld);
    end
    vectors++;
    if (res !== 96'h0 || err !== 4'h0 || so !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data: res=%h err=%b so=%0d, required 0 0000 0", res, err, so);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (so !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_idle: so=%0d, required 0", so);
    end
  endtask

  task automatic test_clean(input logic [7:0] base, input logic [95:0] exp_res,
                            input string name);
    int lat, reads, vlds;
    push_frame(8'h55, base, 1'b0, 0);
    run_frame(12'd14, -1, lat, reads, vlds);
    vectors++;
    if (err !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s_err: got %b, required 0000", name, err);
    end
    vectors++;
    if (res !== exp_res) begin
      miscompares++;
      $display("FAIL %s_res: got %h, required %h", name, res, exp_res);
    end
    vectors++;
    if (reads !== 14) begin
      miscompares++;
      $display("FAIL %s_reads: got %0d, required 14", name, reads);
    end
    vectors++;
    if (vlds !== 1) begin
      miscompares++;
      $display("FAIL %s_vld: got %0d pulses, required 1", name, vlds);
    end
    vectors++;
    if (lat !== 17) begin
      miscompares++;
      $display("FAIL %s_lat: fd at edge %0d, required 17", name, lat);
    end
    end_frame(name);
  endtask

  task automatic test_bad_chk();
    int lat, reads, vlds;
    push_frame(8'h55, 8'hA0, 1'b1, 0);
    run_frame(12'd14, -1, lat, reads, vlds);
    vectors++;
    if (err !== 4'b0100) begin
      miscompares++;
      $display("FAIL chk_err: got %b, required 0100", err);
    end
    vectors++;
    if (res !== 96'h0102030405060708090A0B0C) begin
      miscompares++;
      $display("FAIL chk_res_hold: got %h, required 0102030405060708090a0b0c", res);
    end
    vectors++;
    if (reads !== 14 || vlds !== 0) begin
      miscompares++;
      $display("FAIL chk_reads: reads=%0d vld=%0d, required 14 0", reads, vlds);
    end
    end_frame("chk");
  endtask

  task automatic test_long_frame();
    int lat, reads, vlds;
    push_frame(8'h55, 8'h30, 1'b0, 2);
    run_frame(12'd16, -1, lat, reads, vlds);
    vectors++;
    if (err !== 4'b0010) begin
      miscompares++;
      $display("FAIL len_err: got %b, required 0010", err);
    end
    vectors++;
    if (reads !== 16 || vlds !== 0) begin
      miscompares++;
      $display("FAIL len_reads: reads=%0d vld=%0d, required 16 0", reads, vlds);
    end
    vectors++;
    if (lat !== 19) begin
      miscompares++;
      $display("FAIL len_lat: fd at edge %0d, required 19", lat);
    end
    end_frame("len");
  endtask

  task automatic test_header();
    int lat, reads, vlds;
    push_frame(8'hAA, 8'h40, 1'b0, 0);
    run_frame(12'd14, -1, lat, reads, vlds);
    vectors++;
    if (err !== 4'b0001 || fd !== 1'b1) begin
      miscompares++;
      $display("FAIL head_err: err=%b fd=%0b, required 0001 1", err, fd);
    end
    vectors++;
    if (res !== 96'h1112131415161718191A1B1C || vlds !== 0) begin
      miscompares++;
      $display("FAIL head_hold: res=%h vld=%0d, required 1112..1c 0", res, vlds);
    end
    end_frame("head");
  endtask

  task automatic test_timeout();
    int lat, reads, vlds;
    run_frame(12'd14, 5, lat, reads, vlds);
    vectors++;
    if (err !== 4'b1000 || fd !== 1'b1) begin
      miscompares++;
      $display("FAIL tout_err: err=%b fd=%0b, required 1000 1", err, fd);
    end
    vectors++;
    if (lat !== 100) begin
      miscompares++;
      $display("FAIL tout_lat: fd at edge %0d, required 100", lat);
    end
    vectors++;
    if (reads !== 0) begin
      miscompares++;
      $display("FAIL tout_reads: got %0d, required 0", reads);
    end
    end_frame("tout");
  endtask

  task automatic test_zero_len();
    int lat, reads, vlds;
    run_frame(12'd0, 0, lat, reads, vlds);
    vectors++;
    if (err !== 4'b0010 || reads !== 0 || lat !== 1) begin
      miscompares++;
      $display("FAIL zero_len: err=%b reads=%0d lat=%0d, required 0010 0 1", err, reads, lat);
    end
    end_frame("zero");
  endtask

  task automatic test_rst_mid();
    int rb;
    bit hit;
    rb = rd_count;
    hit = 1'b0;
    push_frame(8'h55, 8'h50, 1'b0, 0);
    fifo_num = 12'd14;
    fifo_cnt = 10'(fifo_q.size());
    @(negedge clk) fs = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_count - rb == 6 && fifo_rxen) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rst_reach: byte 6 read never reached, required reached");
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (fd !== 1'b0 || fifo_rxen !== 1'b0 || res_vld !== 1'b0 || res !== 96'h0 ||
        err !== 4'h0 || so !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid: fd=%0b rxen=%0b vld=%0b res=%h err=%b so=%0d, required all 0",
               fd, fifo_rxen, res_vld, res, err, so);
    end
    fs = 1'b0;
    fifo_q.delete();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_clean(8'h00, 96'h0102030405060708090A0B0C, "clean1");
    test_bad_chk();
    test_long_frame();
    test_clean(8'h10, 96'h1112131415161718191A1B1C, "after_len");
    test_header();
    test_timeout();
    test_zero_len();
    test_rst_mid();
    test_clean(8'h20, 96'h2122232425262728292A2B2C, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
